// File: rtl/uart_led_cmd_ctrl.sv
// uart_led_cmd_ctrl
// Framed LED command controller between a UART RX byte core and six LEDs.
// Frame format: 0xA5, CMD, DATA, CHK where CHK = CMD ^ DATA.
// Commands: 01 SET, 02 OR, 03 CLR, 04 TGL (DATA[5:0] is the LED mask).
// Optional build macro LED_BLINK_EN adds cmd 05 BLINK, which sets a mask of
// LEDs that are inverted on a free-running blink phase.
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   rx_valid_i   one-cycle strobe, rx_data_i holds a received byte
//   rx_data_i    received byte
//   rx_err_i     one-cycle strobe, UART framing error
//   led_o        {led1_b,led1_g,led1_r,led0_b,led0_g,led0_r}, active high
//   frame_ok_o   one-cycle pulse, valid frame applied
//   frame_err_o  one-cycle pulse, frame rejected
//   err_count_o  saturating count of frame_err_o pulses
module uart_led_cmd_ctrl #(
  parameter int TIMEOUT_CLKS    = 100_000,
  parameter int BLINK_HALF_CLKS = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_err_i,
  output logic [5:0] led_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [7:0] err_count_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_GET_CMD  = 2'd1;
  localparam logic [1:0] S_GET_DATA = 2'd2;
  localparam logic [1:0] S_GET_CHK  = 2'd3;

  localparam logic [7:0] HDR     = 8'hA5;
  localparam logic [7:0] CMD_SET = 8'h01;
  localparam logic [7:0] CMD_OR  = 8'h02;
  localparam logic [7:0] CMD_CLR = 8'h03;
  localparam logic [7:0] CMD_TGL = 8'h04;
  localparam logic [7:0] CMD_BLK = 8'h05;

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  // Catch configurations that would make the counters degenerate.
  if (TIMEOUT_CLKS < 2 || BLINK_HALF_CLKS < 2) begin : g_bad_cfg
    $error("uart_led_cmd_ctrl: TIMEOUT_CLKS and BLINK_HALF_CLKS must be >= 2");
  end

  logic [1:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    data_q, data_d;
  logic [5:0]    led_q, led_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [7:0]    errcnt_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cmd_legal;
  logic          tmo_hit;

`ifdef LED_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF_CLKS);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_HALF_CLKS - 1);

  logic [5:0]    mask_q, mask_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [5:0]    led_out_q;

  assign cmd_legal = (cmd_q >= CMD_SET) && (cmd_q <= CMD_BLK);
`else
  assign cmd_legal = (cmd_q >= CMD_SET) && (cmd_q <= CMD_TGL);
`endif

  assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_LAST);

  // Priority: rx_err over a same-cycle byte, a byte over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    led_d   = led_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    tmo_d   = (state_q == S_IDLE) ? '0 : tmo_q + 1'b1;
`ifdef LED_BLINK_EN
    mask_d  = mask_q;
`endif
    if (rx_err_i) begin
      tmo_d = '0;
      if (state_q != S_IDLE) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end else if (rx_valid_i) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE:     if (rx_data_i == HDR) state_d = S_GET_CMD;
        S_GET_CMD:  begin cmd_d  = rx_data_i; state_d = S_GET_DATA; end
        S_GET_DATA: begin data_d = rx_data_i; state_d = S_GET_CHK;  end
        default: begin
          state_d = S_IDLE;
          if (cmd_legal && rx_data_i == (cmd_q ^ data_q)) begin
            ok_d = 1'b1;
            case (cmd_q)
              CMD_SET: led_d = data_q[5:0];
              CMD_OR:  led_d = led_q | data_q[5:0];
              CMD_CLR: led_d = led_q & ~data_q[5:0];
              CMD_TGL: led_d = led_q ^ data_q[5:0];
`ifdef LED_BLINK_EN
              CMD_BLK: mask_d = data_q[5:0];
`endif
              default: led_d = led_q;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (tmo_hit) begin
      tmo_d   = '0;
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      data_q   <= '0;
      led_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      led_q   <= led_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      if (err_d && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
    end
  end

`ifdef LED_BLINK_EN
  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (bcnt_q == BLK_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  // Output register is fed from next-state values so led_o keeps the same
  // one-cycle latency as the LED register itself.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask_q    <= '0;
      phase_q   <= 1'b0;
      bcnt_q    <= '0;
      led_out_q <= '0;
    end else begin
      mask_q    <= mask_d;
      phase_q   <= phase_d;
      bcnt_q    <= bcnt_d;
      led_out_q <= led_d ^ (mask_d & {6{phase_d}});
    end
  end

  assign led_o = led_out_q;
`else
  assign led_o = led_q;
`endif

  assign frame_ok_o  = ok_q;
  assign frame_err_o = err_q;
  assign err_count_o = errcnt_q;

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
module tb_uart_led_cmd_ctrl;
  localparam int TMO = 200;
  localparam int BHC = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_err = 1'b0;
  logic [5:0] led;
  logic       frame_ok, frame_err;
  logic [7:0] err_count;

  uart_led_cmd_ctrl #(.TIMEOUT_CLKS(TMO), .BLINK_HALF_CLKS(BHC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_err_i(rx_err), .led_o(led), .frame_ok_o(frame_ok),
    .frame_err_o(frame_err), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_ok = 0, n_err = 0, n_both = 0;

  // Pulse monitor: a pulse held two cycles counts twice and is caught.
  always @(negedge clk) begin
    if (frame_ok)  n_ok++;
    if (frame_err) n_err++;
    if (frame_ok && frame_err) n_both++;
  end

  // Reference model: frame buffer filled by byte position.
  logic [5:0] m_led = '0;
  int         m_errs = 0, m_ok_ev = 0, m_err_ev = 0;
  int         m_pos = 0;
  logic [7:0] m_frm [0:3];

  function automatic bit m_legal(input logic [7:0] c);
`ifdef LED_BLINK_EN
    return c >= 8'd1 && c <= 8'd5;
`else
    return c >= 8'd1 && c <= 8'd4;
`endif
  endfunction

  function void m_reject();
    m_err_ev++;
    if (m_errs < 255) m_errs++;
  endfunction

  function void m_byte(input logic [7:0] b);
    if (m_pos == 0) begin
      if (b == 8'hA5) m_pos = 1;
    end else begin
      m_frm[m_pos] = b;
      m_pos++;
      if (m_pos == 4) begin
        m_pos = 0;
        if (m_legal(m_frm[1]) && m_frm[3] == (m_frm[1] ^ m_frm[2])) begin
          m_ok_ev++;
          case (m_frm[1])
            8'd1: m_led = m_frm[2][5:0];
            8'd2: m_led = m_led | m_frm[2][5:0];
            8'd3: m_led = m_led & ~m_frm[2][5:0];
            8'd4: m_led = m_led ^ m_frm[2][5:0];
            default: ;
          endcase
        end else m_reject();
      end
    end
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_err = 1'b0; rx_data = b;
    m_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0; rx_err = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
    drive_byte(8'hA5); drive_byte(c); drive_byte(d); drive_byte(k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3); #1;
    total++;
    if (led !== 6'h00 || frame_ok !== 1'b0 || frame_err !== 1'b0 || err_count !== 8'h00) begin
      bad++;
      $display("FAIL reset: led=%h ok=%b err=%b cnt=%h, want all 0", led, frame_ok, frame_err, err_count);
    end
    @(negedge clk); rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_directed();
    logic [7:0] tv [0:5][0:2];
    tv[0] = '{8'h01, 8'h15, 8'h14};
    tv[1] = '{8'h02, 8'h22, 8'h20};
    tv[2] = '{8'h03, 8'h05, 8'h06};
    tv[3] = '{8'h04, 8'h3F, 8'h3B};
    tv[4] = '{8'h01, 8'h3F, 8'h00};
    tv[5] = '{8'h07, 8'h00, 8'h07};
    for (int i = 0; i < 6; i++) begin
      int ok0, err0;
      ok0 = m_ok_ev; err0 = m_err_ev;
      send_frame(tv[i][0], tv[i][1], tv[i][2]);
      idle(1); #1;
      total++;
      if (led !== m_led || err_count !== 8'(m_errs) || frame_ok !== (m_ok_ev != ok0)
          || frame_err !== (m_err_ev != err0)) begin
        bad++;
        $display("FAIL directed[%0d]: led=%h/%h cnt=%h/%h ok=%b err=%b", i, led, m_led,
                 err_count, 8'(m_errs), frame_ok, frame_err);
      end
      idle(1);
    end
    // Junk in IDLE is silently dropped.
    drive_byte(8'h00); drive_byte(8'hFF); drive_byte(8'h5A);
    idle(3); #1;
    total++;
    if (n_ok != m_ok_ev || n_err != m_err_ev || led !== m_led || err_count !== 8'(m_errs)) begin
      bad++;
      $display("FAIL junk: ok=%0d/%0d err=%0d/%0d led=%h/%h", n_ok, m_ok_ev, n_err, m_err_ev, led, m_led);
    end
`ifndef LED_BLINK_EN
    send_frame(8'h05, 8'h03, 8'h06);
    idle(2); #1;
    total++;
    if (n_err != m_err_ev || led !== m_led || err_count !== 8'(m_errs)) begin
      bad++;
      $display("FAIL cmd05_illegal: err=%0d/%0d led=%h/%h", n_err, m_err_ev, led, m_led);
    end
`endif
  endtask

  task automatic test_timeout();
    int err0;
    drive_byte(8'hA5); drive_byte(8'h01);
    idle(1); #1;
    err0 = n_err;
    idle(TMO - 10); #1;
    total++;
    if (n_err != err0) begin
      bad++;
      $display("FAIL timeout_early: err pulses=%0d, want %0d", n_err, err0);
    end
    idle(20); #1;
    m_pos = 0; m_reject();
    total++;
    if (n_err != m_err_ev || led !== m_led || err_count !== 8'(m_errs)) begin
      bad++;
      $display("FAIL timeout: err=%0d/%0d led=%h/%h cnt=%h/%h", n_err, m_err_ev, led, m_led,
               err_count, 8'(m_errs));
    end
    send_frame(8'h01, 8'h3F, 8'h3E);
    idle(2); #1;
    total++;
    if (led !== 6'h3F || led !== m_led || n_ok != m_ok_ev) begin
      bad++;
      $display("FAIL after_timeout: led=%h want 3f ok=%0d/%0d", led, n_ok, m_ok_ev);
    end
  endtask

  task automatic test_rx_err();
    // rx_err in IDLE is ignored.
    @(negedge clk); rx_valid = 1'b0; rx_err = 1'b1;
    idle(2); #1;
    total++;
    if (n_err != m_err_ev) begin
      bad++;
      $display("FAIL rx_err_idle: err=%0d want %0d", n_err, m_err_ev);
    end
    drive_byte(8'hA5); drive_byte(8'h01);
    @(negedge clk); rx_valid = 1'b0; rx_err = 1'b1;
    m_pos = 0; m_reject();
    idle(2); #1;
    total++;
    if (n_err != m_err_ev || led !== m_led || err_count !== 8'(m_errs)) begin
      bad++;
      $display("FAIL rx_err: err=%0d/%0d led=%h/%h", n_err, m_err_ev, led, m_led);
    end
    // Same-cycle rx_err and byte in GET_CMD: byte discarded, FSM idles, so
    // the follow-on bytes must not complete a frame.
    drive_byte(8'hA5);
    @(negedge clk); rx_valid = 1'b1; rx_err = 1'b1; rx_data = 8'h01;
    m_pos = 0; m_reject();
    drive_byte(8'h01); drive_byte(8'h3F); drive_byte(8'h3E);
    idle(3); #1;
    total++;
    if (n_err != m_err_ev || n_ok != m_ok_ev || led !== m_led) begin
      bad++;
      $display("FAIL rx_err_with_byte: err=%0d/%0d ok=%0d/%0d led=%h/%h", n_err, m_err_ev,
               n_ok, m_ok_ev, led, m_led);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] c, d, k;
      c = 8'($urandom_range(0, 7));
`ifdef LED_BLINK_EN
      if (c == 8'd5) c = 8'd2;
`endif
      d = 8'($urandom);
      k = ($urandom_range(0, 3) != 0) ? (c ^ d) : 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h00;
        drive_byte(j);
      end
      send_frame(c, d, k);
      idle($urandom_range(1, 4)); #1;
      total++;
      if (led !== m_led || err_count !== 8'(m_errs) || n_ok != m_ok_ev || n_err != m_err_ev) begin
        bad++;
        $display("FAIL random[%0d] %h %h %h: led=%h/%h cnt=%h/%h ok=%0d/%0d err=%0d/%0d", i, c, d, k,
                 led, m_led, err_count, 8'(m_errs), n_ok, m_ok_ev, n_err, m_err_ev);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      logic [7:0] c, d;
      c = 8'($urandom_range(1, 4));
      d = 8'($urandom);
      send_frame(c, d, ($urandom_range(0, 4) == 0) ? ~(c ^ d) : (c ^ d));
    end
    idle(2); #1;
    total++;
    if (led !== m_led || err_count !== 8'(m_errs) || n_ok != m_ok_ev || n_err != m_err_ev) begin
      bad++;
      $display("FAIL back_to_back: led=%h/%h cnt=%h/%h ok=%0d/%0d err=%0d/%0d", led, m_led,
               err_count, 8'(m_errs), n_ok, m_ok_ev, n_err, m_err_ev);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) send_frame(8'h07, 8'h00, 8'h00);
    idle(2); #1;
    total++;
    if (err_count !== 8'hFF || m_errs != 255 || n_err != m_err_ev || led !== m_led) begin
      bad++;
      $display("FAIL saturate: cnt=%h want ff err=%0d/%0d led=%h/%h", err_count, n_err, m_err_ev,
               led, m_led);
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h01, 8'h2A, 8'h2B);
    drive_byte(8'hA5); drive_byte(8'h01);
    @(negedge clk); rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (led !== 6'h00 || frame_ok !== 1'b0 || frame_err !== 1'b0 || err_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_midframe: led=%h ok=%b err=%b cnt=%h, want all 0", led, frame_ok,
               frame_err, err_count);
    end
    m_led = '0; m_errs = 0; m_pos = 0;
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    send_frame(8'h04, 8'h01, 8'h05);
    idle(2); #1;
    total++;
    if (led !== 6'h01 || led !== m_led || err_count !== 8'h00 || n_ok != m_ok_ev) begin
      bad++;
      $display("FAIL post_reset_frame: led=%h want 01 cnt=%h ok=%0d/%0d", led, err_count, n_ok, m_ok_ev);
    end
  endtask

`ifdef LED_BLINK_EN
  task automatic test_blink();
    int last_chg, nchg, bad_iv, upper_bad;
    logic [5:0] prev;
    send_frame(8'h03, 8'h3F, 8'h3C);
    send_frame(8'h05, 8'h03, 8'h06);
    idle(1); #1;
    prev = led; last_chg = -1; nchg = 0; bad_iv = 0; upper_bad = 0;
    for (int t = 0; t < 450; t++) begin
      idle(1); #1;
      if (led[5:2] !== 4'h0) upper_bad++;
      if (led !== prev) begin
        if (last_chg >= 0 && t - last_chg != BHC) bad_iv++;
        last_chg = t; nchg++;
        prev = led;
      end
    end
    total++;
    if (nchg < 3 || bad_iv != 0 || upper_bad != 0) begin
      bad++;
      $display("FAIL blink: changes=%0d bad_intervals=%0d upper_set=%0d", nchg, bad_iv, upper_bad);
    end
  endtask
`endif

  task automatic test_exclusive();
    total++;
    if (n_both != 0) begin
      bad++;
      $display("FAIL ok_err_exclusive: both-high cycles=%0d want 0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_rx_err();
    test_random();
    test_back_to_back();
    test_saturate();
    test_reset_midframe();
`ifdef LED_BLINK_EN
    test_blink();
`endif
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/uart_led_cmd_ctrl.md
Name: uart_led_cmd_ctrl

Overview:
- Command controller that sits between the UART RX byte core and the six board LEDs (led0 RGB, led1 RGB).
- Replaces direct byte-to-LED mapping with a framed protocol: 0xA5 header, CMD, DATA, CHK.
- Parses frames with an FSM, validates the checksum, applies set/or/clear/toggle operations to an LED register, and recovers from line errors and stalled frames via an inter-byte timeout.

Parameters:
- TIMEOUT_CLKS, 100_000, clocks allowed between bytes inside a frame before abort (1 ms at 100 MHz).
- BLINK_HALF_CLKS, 50_000_000, half period of the blink phase in clocks (used only with LED_BLINK_EN).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received byte.
- rx_err  input  1  one-cycle strobe: UART framing error (bad stop bit).
- led  output  6  {led1_b, led1_g, led1_r, led0_b, led0_g, led0_r}, active high.
- frame_ok  output  1  one-cycle pulse: valid frame applied.
- frame_err  output  1  one-cycle pulse: frame rejected (checksum, unknown cmd, timeout, rx_err).
- err_count  output  8  saturating count of frame_err pulses.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, led_reg=6'h00, led=6'h00, frame_ok=0, frame_err=0, err_count=0, timeout counter=0.
- FSM states: IDLE, GET_CMD, GET_DATA, GET_CHK. Every byte is consumed positionally.
  - IDLE: byte 0xA5 -> GET_CMD. Any other byte is ignored silently (no error).
  - GET_CMD: latch cmd -> GET_DATA. A byte of 0xA5 here is taken as a cmd value, not a resync.
  - GET_DATA: latch data -> GET_CHK.
  - GET_CHK: ok = (byte == cmd ^ data) and cmd is legal -> apply cmd, pulse frame_ok. Otherwise pulse frame_err. Always -> IDLE.
- Commands (only data[5:0] used; data[7:6] ignored):
  - 0x01 SET: led_reg <= data[5:0].
  - 0x02 OR: led_reg <= led_reg | data[5:0].
  - 0x03 CLR: led_reg <= led_reg & ~data[5:0].
  - 0x04 TGL: led_reg <= led_reg ^ data[5:0].
  - Any other cmd is illegal and produces frame_err.
- Latency: CHK byte with rx_valid high at edge N -> led, frame_ok/frame_err updated at edge N+1. All outputs registered.
- Timeout:
  - Counter clears on every rx_valid and runs only in GET_CMD, GET_DATA, GET_CHK.
  - When it reaches TIMEOUT_CLKS-1 with no byte: -> IDLE, pulse frame_err, led_reg unchanged.
  - In IDLE the counter is held at 0.
- rx_err: in any non-IDLE state -> IDLE, pulse frame_err, led_reg unchanged. In IDLE it is ignored.
- Simultaneous events:
  - rx_err and rx_valid in the same cycle: rx_err wins and the byte is discarded.
  - rx_valid in the same cycle as timeout expiry: the byte wins and the counter resets.
  - At most one frame_err pulse per cycle.
- err_count: increments on each frame_err and saturates at 8'hFF (no wrap).
- frame_ok and frame_err are never high in the same cycle.
- Reset mid-frame: immediate return to the reset state. The partial frame is lost.

Optional Feature:
- LED_BLINK_EN defined:
  - Adds cmd 0x05 BLINK: blink_mask <= data[5:0].
  - A free-running counter toggles blink_phase every BLINK_HALF_CLKS clocks.
  - led = led_reg ^ (blink_mask & {6{blink_phase}}).
  - blink_mask and blink_phase reset to 0.
- LED_BLINK_EN undefined:
  - 0x05 is illegal and produces frame_err.
  - led = led_reg.
  - No blink counter or mask logic is present.

Test Plan:
- Send A5 01 15 14 -> one cycle after CHK, led=6'h15, frame_ok pulses once, err_count=0.
- From led=6'h15, send A5 02 22 20 -> led=6'h37. Then A5 03 05 06 -> led=6'h32. Then A5 04 3F 3B -> led=6'h0D.
- Bad checksum or illegal cmd:
  - Send A5 01 3F 00 -> frame_err pulse, led unchanged, err_count=1.
  - Send A5 07 00 07 -> frame_err, err_count=2.
  - Leading junk bytes 00 FF 5A in IDLE -> no pulses.
- Timeout: send A5 01, then idle TIMEOUT_CLKS clocks (bench overrides TIMEOUT_CLKS=200) -> frame_err, FSM back to IDLE. A following full frame A5 01 3F 3E -> led=6'h3F.
- rx_err after A5 01 -> frame_err, led unchanged. Then rx_err and rx_valid asserted in the same cycle during GET_CMD -> frame_err, and the byte is not used as a cmd.
- Saturation and reset:
  - Force 300 bad frames -> err_count holds 8'hFF.
  - Assert rst_n=0 mid-frame (after A5 01) -> all outputs 0 immediately.
  - With LED_BLINK_EN, BLINK_HALF_CLKS=100, led_reg=0: A5 05 03 06 -> led[1:0] toggles every 100 clocks.
